// File: rtl/cnn_pkg.sv
// Shared types and constants for the CNN frame controller: frame states,
// image geometry and the layout of the result byte returned to USB.
package cnn_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        LABEL,
        FWD,
        BWD,
        OUT
    } frame_state_t;

    localparam int IMAGE_SIZE   = 28;
    localparam int IMAGE_PIXELS = IMAGE_SIZE * IMAGE_SIZE;
    localparam int NUM_CLASSES  = 10;

    localparam int RES_TRAIN_BIT = 7;
    localparam int RES_ERR_BIT   = 6;
    localparam int RES_CLASS_LSB = 0;
    localparam int RES_CLASS_W   = 4;

    // Inference frames never carry a label, so the error flag is masked there.
    function automatic logic [7:0] result_byte(input logic train, input logic err,
                                               input logic [3:0] cls);
        logic [7:0] b;
        b = '0;
        b[RES_CLASS_LSB +: RES_CLASS_W] = cls;
        b[RES_TRAIN_BIT] = train;
        b[RES_ERR_BIT]   = train & err;
        return b;
    endfunction

endpackage

// File: rtl/pulse_on_entry.sv
// Registered single-cycle strobe: high for exactly the first cycle a state is occupied.
module pulse_on_entry (
    input  logic clk,
    input  logic rst,
    input  logic enter,
    output logic pulse
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pulse <= 1'b0;
        end else begin
            pulse <= enter;
        end
    end

endmodule

// File: rtl/cnn_frame_ctrl.sv
// Frame controller: loads one image (plus optional label) into the image buffer,
// sequences forward/backward passes and hands the result byte back to USB.
module cnn_frame_ctrl
    import cnn_pkg::*;
#(
    parameter int IMAGE_SIZE   = 28,
    parameter int IMAGE_PIXELS = IMAGE_SIZE * IMAGE_SIZE,
    parameter int NUM_CLASSES  = 10,
    parameter int ADDR_W       = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        usb_data_in,
    input  logic              usb_data_valid,
    input  logic              mode_train,
    output logic              buf_we,
    output logic [ADDR_W-1:0] buf_addr,
    output logic [7:0]        buf_wdata,
    output logic [3:0]        label,
    output logic              fwd_start,
    input  logic              fwd_done,
    input  logic [3:0]        class_idx,
    output logic              bwd_start,
    input  logic              bwd_done,
    output logic [7:0]        usb_data_out,
    output logic              usb_data_ready,
    input  logic              usb_data_ack,
    output logic              busy,
    output logic              overrun
);

    frame_state_t      state_reg, state_next;
    logic [ADDR_W-1:0] cnt_reg, cnt_next;
    logic              mode_reg, mode_next;
    logic              label_err_reg, label_err_next;
    logic [3:0]        label_reg, label_next;
    logic [3:0]        class_reg, class_next;
    logic              we_reg, we_next;
    logic [ADDR_W-1:0] addr_reg, addr_next;
    logic [7:0]        wdata_reg, wdata_next;
    logic [7:0]        out_reg, out_next;
    logic              ready_reg, ready_next;
    logic              overrun_reg, overrun_next;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= IDLE;
            cnt_reg       <= '0;
            mode_reg      <= 1'b0;
            label_err_reg <= 1'b0;
            label_reg     <= '0;
            class_reg     <= '0;
            we_reg        <= 1'b0;
            addr_reg      <= '0;
            wdata_reg     <= '0;
            out_reg       <= '0;
            ready_reg     <= 1'b0;
            overrun_reg   <= 1'b0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            mode_reg      <= mode_next;
            label_err_reg <= label_err_next;
            label_reg     <= label_next;
            class_reg     <= class_next;
            we_reg        <= we_next;
            addr_reg      <= addr_next;
            wdata_reg     <= wdata_next;
            out_reg       <= out_next;
            ready_reg     <= ready_next;
            overrun_reg   <= overrun_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        cnt_next       = cnt_reg;
        mode_next      = mode_reg;
        label_err_next = label_err_reg;
        label_next     = label_reg;
        class_next     = class_reg;
        we_next        = 1'b0;
        addr_next      = addr_reg;
        wdata_next     = wdata_reg;
        out_next       = out_reg;
        ready_next     = ready_reg;
        overrun_next   = overrun_reg;

        case (state_reg)
            IDLE: begin
                if (usb_data_valid) begin
                    mode_next  = mode_train;
                    we_next    = 1'b1;
                    addr_next  = '0;
                    wdata_next = usb_data_in;
                    cnt_next   = ADDR_W'(1);
                    state_next = LOAD;
                end
            end
            LOAD: begin
                if (usb_data_valid) begin
                    we_next    = 1'b1;
                    addr_next  = cnt_reg;
                    wdata_next = usb_data_in;
                    cnt_next   = cnt_reg + ADDR_W'(1);
                    if (cnt_reg == ADDR_W'(IMAGE_PIXELS - 1)) begin
                        state_next = mode_reg ? LABEL : FWD;
                    end
                end
            end
            LABEL: begin
                if (usb_data_valid) begin
                    if (usb_data_in < 8'(NUM_CLASSES)) begin
                        label_next     = usb_data_in[3:0];
                        label_err_next = 1'b0;
                    end else begin
                        label_next     = '0;
                        label_err_next = 1'b1;
                    end
                    state_next = FWD;
                end
            end
            FWD: begin
                if (usb_data_valid) begin
                    overrun_next = 1'b1;
                end
                if (fwd_done) begin
                    class_next = class_idx;
                    if (mode_reg && !label_err_reg) begin
                        state_next = BWD;
                    end else begin
                        out_next   = result_byte(mode_reg, label_err_reg, class_idx);
                        ready_next = 1'b1;
                        state_next = OUT;
                    end
                end
            end
            BWD: begin
                if (usb_data_valid) begin
                    overrun_next = 1'b1;
                end
                if (bwd_done) begin
                    out_next   = result_byte(mode_reg, label_err_reg, class_reg);
                    ready_next = 1'b1;
                    state_next = OUT;
                end
            end
            OUT: begin
                if (usb_data_valid) begin
                    overrun_next = 1'b1;
                end
                // Only an ack seen while ready is already visible completes the handshake.
                if (usb_data_ack && ready_reg) begin
                    ready_next = 1'b0;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    pulse_on_entry u_fwd_pulse (
        .clk   (clk),
        .rst   (rst),
        .enter ((state_next == FWD) && (state_reg != FWD)),
        .pulse (fwd_start)
    );

    pulse_on_entry u_bwd_pulse (
        .clk   (clk),
        .rst   (rst),
        .enter ((state_next == BWD) && (state_reg != BWD)),
        .pulse (bwd_start)
    );

    assign buf_we         = we_reg;
    assign buf_addr       = addr_reg;
    assign buf_wdata      = wdata_reg;
    assign label          = label_reg;
    assign usb_data_out   = out_reg;
    assign usb_data_ready = ready_reg;
    assign busy           = (state_reg != IDLE);
    assign overrun        = overrun_reg;

endmodule

// File: tb/tb_cnn_frame_ctrl.sv
// Scoreboard bench for cnn_frame_ctrl: frame tasks push expected buffer writes and
// result bytes; independent monitors pop and compare whenever the DUT presents them.
`timescale 1ns/1ps
module tb_cnn_frame_ctrl;

    localparam int NPIX   = 784;
    localparam int NCLASS = 10;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] usb_data_in;
    logic       usb_data_valid;
    logic       mode_train;
    logic       buf_we;
    logic [9:0] buf_addr;
    logic [7:0] buf_wdata;
    logic [3:0] label;
    logic       fwd_start;
    logic       fwd_done;
    logic [3:0] class_idx;
    logic       bwd_start;
    logic       bwd_done;
    logic [7:0] usb_data_out;
    logic       usb_data_ready;
    logic       usb_data_ack;
    logic       busy;
    logic       overrun;

    cnn_frame_ctrl dut (
        .clk            (clk),
        .rst            (rst),
        .usb_data_in    (usb_data_in),
        .usb_data_valid (usb_data_valid),
        .mode_train     (mode_train),
        .buf_we         (buf_we),
        .buf_addr       (buf_addr),
        .buf_wdata      (buf_wdata),
        .label          (label),
        .fwd_start      (fwd_start),
        .fwd_done       (fwd_done),
        .class_idx      (class_idx),
        .bwd_start      (bwd_start),
        .bwd_done       (bwd_done),
        .usb_data_out   (usb_data_out),
        .usb_data_ready (usb_data_ready),
        .usb_data_ack   (usb_data_ack),
        .busy           (busy),
        .overrun        (overrun)
    );

    always #5 clk = ~clk;

    typedef struct {
        int addr;
        int data;
    } wr_t;

    wr_t        exp_wr[$];
    logic [7:0] exp_res[$];
    int         n_checks = 0;
    int         n_pass   = 0;
    int         exp_fwd  = 0;
    int         exp_bwd  = 0;
    int         act_fwd  = 0;
    int         act_bwd  = 0;
    logic       exp_overrun = 1'b0;
    logic [3:0] exp_label   = 4'd0;

    function automatic void check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Buffer-write monitor.
    always @(negedge clk) begin
        if (buf_we) begin
            if (exp_wr.size() == 0) begin
                check("unexpected_buf_write", buf_addr, 'hFFFF);
            end else begin
                wr_t w;
                w = exp_wr.pop_front();
                check("buf_addr", buf_addr, w.addr);
                check("buf_wdata", buf_wdata, w.data);
            end
        end
    end

    // Start-strobe counters and result-byte monitor.
    logic       ready_prev = 1'b0;
    logic [7:0] held_out   = 8'h00;
    always @(negedge clk) begin
        if (fwd_start) act_fwd++;
        if (bwd_start) act_bwd++;
        if (usb_data_ready && !ready_prev) begin
            if (exp_res.size() == 0) begin
                check("unexpected_ready", usb_data_out, 'hFFFF);
            end else begin
                logic [7:0] e;
                e = exp_res.pop_front();
                check("result_byte", usb_data_out, e);
                $display("result: usb_data_out=0x%02h expected=0x%02h", usb_data_out, e);
            end
            held_out = usb_data_out;
        end else if (usb_data_ready) begin
            check("result_stable", usb_data_out, held_out);
        end
        ready_prev = usb_data_ready;
    end

    // Reference model: expectations come straight from the frame-level rules.
    task automatic run_frame(input bit train, input logic [7:0] lab, input logic [3:0] cls,
                             input int fwd_dly, input int bwd_dly, input int ack_dly,
                             input bit inject_ovr, input bit ack_early);
        logic [7:0] pix;
        logic [7:0] exp_byte;
        bit ok;
        bit do_bwd;
        ok     = (lab < NCLASS);
        do_bwd = train && ok;
        if (train) exp_label = ok ? lab[3:0] : 4'd0;
        exp_byte = train ? {1'b1, !ok, 2'b00, cls} : {4'h0, cls};
        exp_res.push_back(exp_byte);

        for (int i = 0; i < NPIX; i++) begin
            pix = 8'($urandom);
            exp_wr.push_back('{i, int'(pix)});
            usb_data_valid = 1'b1;
            usb_data_in    = pix;
            mode_train     = (i == 0) ? train : 1'($urandom);
            tick();
        end
        if (train) begin
            usb_data_in = lab;
            tick();
        end
        usb_data_valid = 1'b0;
        check("fwd_start_latency", fwd_start, 1);
        exp_fwd++;
        if (do_bwd) exp_bwd++;

        bwd_done = 1'b1;
        tick();
        bwd_done = 1'b0;
        check("spurious_bwd_done_ignored", usb_data_ready, 0);

        if (inject_ovr) begin
            usb_data_valid = 1'b1;
            usb_data_in    = 8'($urandom);
            tick();
            usb_data_valid = 1'b0;
            exp_overrun    = 1'b1;
        end
        repeat (fwd_dly) tick();
        check("busy_in_fwd", busy, 1);

        fwd_done     = 1'b1;
        class_idx    = cls;
        usb_data_ack = ack_early;
        tick();
        fwd_done     = 1'b0;
        class_idx    = ~cls;
        usb_data_ack = 1'b0;
        check("bwd_start_after_fwd_done", bwd_start, do_bwd);
        check("ready_after_fwd_done", usb_data_ready, !do_bwd);

        if (do_bwd) begin
            fwd_done = 1'b1;
            tick();
            fwd_done = 1'b0;
            repeat (bwd_dly) tick();
            bwd_done     = 1'b1;
            usb_data_ack = ack_early;
            tick();
            bwd_done     = 1'b0;
            usb_data_ack = 1'b0;
            check("ready_after_bwd_done", usb_data_ready, 1);
        end

        for (int k = 0; k < ack_dly; k++) begin
            check("ready_held", usb_data_ready, 1);
            tick();
        end
        usb_data_ack = 1'b1;
        tick();
        usb_data_ack = 1'b0;
        check("ready_cleared_by_ack", usb_data_ready, 0);
        check("idle_after_ack", busy, 0);
        check("label", label, exp_label);
        check("overrun", overrun, exp_overrun);
        check("fwd_start_count", act_fwd, exp_fwd);
        check("bwd_start_count", act_bwd, exp_bwd);
        $display("frame: train=%0d label_byte=%0d class=%0d result=0x%02h", train, lab, cls, exp_byte);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_buf_we"}, buf_we, 0);
        check({tag, "_buf_addr"}, buf_addr, 0);
        check({tag, "_buf_wdata"}, buf_wdata, 0);
        check({tag, "_label"}, label, 0);
        check({tag, "_fwd_start"}, fwd_start, 0);
        check({tag, "_bwd_start"}, bwd_start, 0);
        check({tag, "_usb_data_out"}, usb_data_out, 0);
        check({tag, "_usb_data_ready"}, usb_data_ready, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_overrun"}, overrun, 0);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst            = 1'b1;
        usb_data_in    = 8'h00;
        usb_data_valid = 1'b0;
        mode_train     = 1'b0;
        fwd_done       = 1'b0;
        class_idx      = 4'h0;
        bwd_done       = 1'b0;
        usb_data_ack   = 1'b0;
        tick();
        tick();
        check_reset_outputs("reset");
        rst = 1'b0;
        tick();

        run_frame(1'b0, 8'd0,  4'd7, 5, 0, 3,  1'b0, 1'b0);
        run_frame(1'b1, 8'd3,  4'd3, 4, 6, 2,  1'b0, 1'b0);
        run_frame(1'b1, 8'd12, 4'd5, 3, 0, 1,  1'b0, 1'b0);
        run_frame(1'b0, 8'd0,  4'd2, 6, 0, 1,  1'b1, 1'b0);
        run_frame(1'b1, 8'd9,  4'd14, 2, 3, 20, 1'b0, 1'b1);

        // Abort a frame after 400 pixels; written bytes are expected, nothing after.
        for (int i = 0; i < 400; i++) begin
            logic [7:0] p;
            p = 8'($urandom);
            exp_wr.push_back('{i, int'(p)});
            usb_data_valid = 1'b1;
            usb_data_in    = p;
            mode_train     = 1'b0;
            tick();
        end
        usb_data_valid = 1'b0;
        tick();
        rst = 1'b1;
        #1;
        exp_overrun = 1'b0;
        exp_label   = 4'd0;
        check_reset_outputs("midframe_reset");
        check("partial_writes_seen", exp_wr.size(), 0);
        tick();
        rst = 1'b0;
        tick();
        run_frame(1'b0, 8'd0, 4'd4, 5, 0, 2, 1'b0, 1'b0);

        for (int f = 0; f < 3; f++) begin
            run_frame(1'($urandom), 8'($urandom_range(0, 15)), 4'($urandom),
                      $urandom_range(0, 8), $urandom_range(0, 8), $urandom_range(0, 5),
                      1'($urandom), 1'($urandom));
        end

        tick();
        check("no_pending_writes", exp_wr.size(), 0);
        check("no_pending_results", exp_res.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/cnn_frame_ctrl.md
# cnn_frame_ctrl

Frame-level controller for the MNIST CNN. It assembles one 28x28 image (plus a label byte in training mode) from the USB byte stream into the image buffer. It then sequences the forward pass and, when training, the backward pass through start/done handshakes, and returns the classification byte to USB. It replaces the per-byte ad hoc control in `cnn_top` and is the only block that drives the datapath start strobes.

## Interface
- `IMAGE_SIZE`, 28, image side length in pixels
- `IMAGE_PIXELS`, `IMAGE_SIZE*IMAGE_SIZE` (784), pixel bytes per frame
- `NUM_CLASSES`, 10, number of valid labels and classes
- `ADDR_W`, 10, image buffer address width; must satisfy 2^ADDR_W >= IMAGE_PIXELS
- `clk` in 1: single clock, all logic on rising edge
- `rst` in 1: asynchronous, active-high reset
- `usb_data_in` in 8: pixel or label byte
- `usb_data_valid` in 1: `usb_data_in` valid this cycle; no backpressure
- `mode_train` in 1: 1 = training frame, 0 = inference frame; latched at first pixel
- `buf_we` out 1: image buffer write strobe
- `buf_addr` out ADDR_W: image buffer write address
- `buf_wdata` out 8: image buffer write data
- `label` out 4: latched ground-truth label, stable from BWD entry until the next frame's first pixel
- `fwd_start` out 1: one-cycle pulse that starts the forward pass
- `fwd_done` in 1: forward pass complete; `class_idx` is valid in the same cycle
- `class_idx` in 4: argmax class from the FC layer
- `bwd_start` out 1: one-cycle pulse that starts the backward pass
- `bwd_done` in 1: backward pass complete
- `usb_data_out` out 8: result byte
- `usb_data_ready` out 1: result byte valid; held until acknowledged
- `usb_data_ack` in 1: host consumed the result byte
- `busy` out 1: high in every state except IDLE
- `overrun` out 1: sticky; a byte arrived while it could not be accepted

## Operation
- Reset values: `buf_we`=0, `buf_addr`=0, `buf_wdata`=0, `label`=0, `fwd_start`=0, `bwd_start`=0, `usb_data_out`=0, `usb_data_ready`=0, `busy`=0, `overrun`=0. Internal state is IDLE, with pixel counter 0 and `label_err`=0.
- States:
  - **IDLE**: on `usb_data_valid`, latch `mode_train`, write the byte to address 0, set pixel counter=1, go to LOAD.
  - **LOAD**: each valid byte writes to address = counter, then the counter increments. When the byte at address `IMAGE_PIXELS-1` is written, go to LABEL if training, otherwise go to FWD.
  - **LABEL**: the next valid byte is the label and is not written to the buffer. If the byte is < `NUM_CLASSES`, `label`<=byte[3:0] and `label_err`<=0. Otherwise `label`<=0 and `label_err`<=1. Go to FWD.
  - **FWD**: pulse `fwd_start` on the entry cycle only. Wait for `fwd_done`, then capture `class_idx`. If training and `label_err`=0, go to BWD; otherwise go to OUT.
  - **BWD**: pulse `bwd_start` on the entry cycle only. Wait for `bwd_done`, then go to OUT.
  - **OUT**: set `usb_data_ready`=1. Inference output is `usb_data_out`={4'h0, class_idx}. Training output is {1'b1, label_err, 2'b00, class_idx}. When `usb_data_ack` is seen with ready high, clear ready and go to IDLE.
- `usb_data_valid` in FWD, BWD or OUT: the byte is dropped and `overrun`<=1. Only `rst` clears `overrun`.
- `fwd_done` or `bwd_done` outside its own wait state is ignored.
- `mode_train` changes after the first pixel have no effect until the next frame.
- `class_idx` >= `NUM_CLASSES` is passed through unchanged.

## Timing
- Buffer write is registered. A byte valid in cycle N produces `buf_we`/`buf_addr`/`buf_wdata` in cycle N+1, and `buf_we` lasts one cycle per byte.
- Back-to-back valid bytes are accepted every cycle.
- `fwd_start` asserts the cycle after the last pixel write (inference) or after the label cycle (training).
- `fwd_done` in cycle N gives `bwd_start` in N+1, or `usb_data_ready` in N+1.
- `bwd_done` in cycle N gives `usb_data_ready` in N+1.
- Acknowledge: `usb_data_ack` in cycle N gives ready low and IDLE in N+1. The next frame's first byte is accepted in N+1.
- An ack in the same cycle ready first rises is not honoured; ready must be seen high first.
- `rst` mid-frame aborts immediately. The partial frame is discarded, no strobes are issued, and the next frame restarts at address 0.

## Structure
- Package `cnn_pkg`: state enum `frame_state_t` (IDLE, LOAD, LABEL, FWD, BWD, OUT), `IMAGE_PIXELS`, `NUM_CLASSES`, and result-byte field positions.
- One sub-module, `pulse_on_entry`: it generates the single-cycle start strobe from a state-entry condition and is instantiated twice (fwd and bwd).
- Everything else lives in one FSM plus a pixel counter.

## Test plan
- **Inference frame.** Stimulus: 784 bytes, mode_train=0, `fwd_done` 5 cycles after `fwd_start` with class_idx=7. Response: 784 `buf_we` pulses, addresses 0..783; one `fwd_start`; no `bwd_start`; `usb_data_out`=0x07 with ready held until ack.
- **Training frame.** Stimulus: 784 pixels plus label 3, class_idx=3. Response: `label`=3; `bwd_start` one cycle after `fwd_done`; `usb_data_out`=0x83 after `bwd_done`.
- **Bad label.** Stimulus: label byte 12. Response: no `bwd_start`; `usb_data_out`=0xC0|class_idx; `label`=0.
- **Overrun.** Stimulus: a valid byte during FWD. Response: `overrun`=1 and stays high through the next frame; the buffer is not written.
- **Reset mid-frame.** Stimulus: `rst` after 400 pixels, then a full frame. Response: addressing restarts at 0 and the frame completes normally.
- **Ack hold.** Stimulus: delay ack 20 cycles, then assert ack. Response: ready stays high and output stays stable for the whole delay; IDLE the next cycle; a back-to-back next frame is accepted.
